// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single synchronous dmem.
// One access at a time: IDLE -> ISSUE -> WAIT -> IDLE.
module dmem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              wren0_i,
  input  logic              wren1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              done0_o,
  output logic              done1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] address_dmem_o,
  output logic [DATA_W-1:0] data_o,
  output logic              wren_o,
  input  logic [DATA_W-1:0] q_dmem_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              op_wr_q, op_wr_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              win1;

  // Port 1 wins when alone, or on a tie when port 0 was served last.
  assign win1 = req1_i & (~req0_i | ~last_q);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    op_wr_d  = op_wr_q;
    wren_d   = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      S_IDLE: begin
        if (req0_i | req1_i) begin
          state_d = S_ISSUE;
          owner_d = win1;
          last_d  = win1;
          op_wr_d = win1 ? wren1_i : wren0_i;
          wren_d  = op_wr_d;
          addr_d  = win1 ? addr1_i : addr0_i;
          data_d  = win1 ? wdata1_i : wdata0_i;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        state_d = S_IDLE;
        done0_d = ~owner_q;
        done1_d = owner_q;
        if (!op_wr_q) begin
          if (owner_q) rdata1_d = q_dmem_i;
          else         rdata0_d = q_dmem_i;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      op_wr_q  <= 1'b0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      op_wr_q  <= op_wr_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign gnt0_o         = (state_q == S_ISSUE) & ~owner_q;
  assign gnt1_o         = (state_q == S_ISSUE) & owner_q;
  assign done0_o        = done0_q;
  assign done1_o        = done1_q;
  assign rdata0_o       = rdata0_q;
  assign rdata1_o       = rdata1_q;
  assign busy_o         = (state_q != S_IDLE);
  assign address_dmem_o = addr_q;
  assign data_o         = data_q;
  // Reset on the ISSUE edge must beat the dmem write.
  assign wren_o         = wren_q & ~reset_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic
// checked against a cycle-schedule reference model.
module tb_dmem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0, req1, wren0, wren1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1, busy, wren;
  logic [DW-1:0] rdata0, rdata1, data, q_dmem;
  logic [AW-1:0] address_dmem;

  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  logic [DW-1:0] mem [0:4095];
  logic [DW-1:0] ref_mem [0:4095];
  logic [5:0]    fl;

  int vecs = 0;
  int errs = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock_i(clock), .reset_i(reset),
    .req0_i(req0), .req1_i(req1),
    .wren0_i(wren0), .wren1_i(wren1),
    .addr0_i(addr0), .addr1_i(addr1),
    .wdata0_i(wdata0), .wdata1_i(wdata1),
    .gnt0_o(gnt0), .gnt1_o(gnt1),
    .done0_o(done0), .done1_o(done1),
    .rdata0_o(rdata0), .rdata1_o(rdata1),
    .busy_o(busy), .address_dmem_o(address_dmem),
    .data_o(data), .wren_o(wren), .q_dmem_i(q_dmem)
  );

  // Synchronous dmem: registered read, write on wren.
  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (wren) mem[address_dmem] <= data;
    q_dmem <= mem[address_dmem];
  end

  assign fl = {gnt0, gnt1, done0, done1, busy, wren};

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    req0 = 0; req1 = 0; wren0 = 0; wren1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic preload(input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    pl_en = 1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    tick;
    pl_en = 0;
  endtask

  task automatic do_reset;
    reset = 1;
    idle_inputs;
    tick;
    tick;
    reset = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    idle_inputs;
    tick;
    tick;
    vecs++;
    if (fl !== 6'b0) begin
      errs++;
      $display("FAIL reset_flags got %b exp %b", fl, 6'b0);
    end
    vecs++;
    if ({address_dmem, data} !== '0) begin
      errs++;
      $display("FAIL reset_addr_data got %h %h exp 0", address_dmem, data);
    end
    vecs++;
    if ({rdata0, rdata1} !== '0) begin
      errs++;
      $display("FAIL reset_rdata got %h %h exp 0", rdata0, rdata1);
    end
    reset = 0;
    tick;
    vecs++;
    if (fl !== 6'b0) begin
      errs++;
      $display("FAIL idle_flags got %b exp %b", fl, 6'b0);
    end
  endtask

  task automatic test_single_read;
    logic [5:0] e;
    preload(12'h010, 32'hDEADBEEF);
    req0 = 1; wren0 = 0; addr0 = 12'h010;
    for (int k = 1; k <= 5; k++) begin
      tick;
      e = {k == 1, 1'b0, k == 3, 1'b0, (k == 1 || k == 2), 1'b0};
      vecs++;
      if (fl !== e) begin
        errs++;
        $display("FAIL single_flags c%0d got %b exp %b", k, fl, e);
      end
      if (k == 1) begin
        vecs++;
        if (address_dmem !== 12'h010) begin
          errs++;
          $display("FAIL single_addr got %h exp 010", address_dmem);
        end
        req0 = 0;
      end
      if (k == 3) begin
        vecs++;
        if (rdata0 !== 32'hDEADBEEF) begin
          errs++;
          $display("FAIL single_rdata got %h exp deadbeef", rdata0);
        end
      end
    end
  endtask

  task automatic test_write_read_p1;
    logic [5:0] e;
    req1 = 1; wren1 = 1; addr1 = 12'h0FF; wdata1 = 32'h12345678;
    for (int k = 1; k <= 7; k++) begin
      tick;
      e = {1'b0, (k == 1 || k == 4), 1'b0, (k == 3 || k == 6),
           (k inside {1, 2, 4, 5}), k == 1};
      vecs++;
      if (fl !== e) begin
        errs++;
        $display("FAIL wr_p1_flags c%0d got %b exp %b", k, fl, e);
      end
      if (k == 1) begin
        vecs++;
        if (data !== 32'h12345678) begin
          errs++;
          $display("FAIL wr_p1_data got %h exp 12345678", data);
        end
        req1 = 0;
      end
      if (k == 3) begin
        vecs++;
        if (rdata1 !== 32'h0) begin
          errs++;
          $display("FAIL wr_p1_rdata_kept got %h exp 0", rdata1);
        end
        vecs++;
        if (mem[12'h0FF] !== 32'h12345678) begin
          errs++;
          $display("FAIL wr_p1_mem got %h exp 12345678", mem[12'h0FF]);
        end
        req1 = 1; wren1 = 0;
      end
      if (k == 4) req1 = 0;
      if (k == 6) begin
        vecs++;
        if (rdata1 !== 32'h12345678) begin
          errs++;
          $display("FAIL rd_p1_rdata got %h exp 12345678", rdata1);
        end
      end
    end
  endtask

  task automatic test_tie;
    logic [AW-1:0] a0 [2];
    logic [AW-1:0] a1 [2];
    logic [DW-1:0] d0 [2];
    logic [DW-1:0] d1 [2];
    logic [5:0]    e;
    int            n, ph, own;
    do_reset;
    for (int i = 0; i < 2; i++) begin
      a0[i] = AW'(32'h200 + i * 128 + $urandom_range(0, 127));
      a1[i] = AW'(32'h300 + i * 128 + $urandom_range(0, 127));
      d0[i] = $urandom;
      d1[i] = $urandom;
      preload(a0[i], d0[i]);
      preload(a1[i], d1[i]);
    end
    req0 = 1; req1 = 1; wren0 = 0; wren1 = 0;
    addr0 = a0[0]; addr1 = a1[0];
    for (int k = 1; k <= 12; k++) begin
      tick;
      n = (k - 1) / 3;
      ph = (k - 1) % 3;
      own = n % 2;
      e = {ph == 0 && own == 0, ph == 0 && own == 1,
           ph == 2 && own == 0, ph == 2 && own == 1, ph < 2, 1'b0};
      vecs++;
      if (fl !== e) begin
        errs++;
        $display("FAIL tie_flags c%0d got %b exp %b", k, fl, e);
      end
      if (ph == 0) begin
        if (own == 0) begin
          if (n / 2 == 0) addr0 = a0[1];
          else req0 = 0;
        end else begin
          if (n / 2 == 0) addr1 = a1[1];
          else req1 = 0;
        end
      end
      if (ph == 2) begin
        vecs++;
        if (own == 0 && rdata0 !== d0[n/2]) begin
          errs++;
          $display("FAIL tie_rdata0 got %h exp %h", rdata0, d0[n/2]);
        end else if (own == 1 && rdata1 !== d1[n/2]) begin
          errs++;
          $display("FAIL tie_rdata1 got %h exp %h", rdata1, d1[n/2]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] d [3];
    logic [5:0]    e;
    int            n, ph;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      d[i] = $urandom;
      preload(AW'(i + 1), d[i]);
    end
    vecs++;
    if (fl !== 6'b0) begin
      errs++;
      $display("FAIL b2b_c0 got %b exp %b", fl, 6'b0);
    end
    req0 = 1; wren0 = 0; addr0 = 12'h001;
    for (int k = 1; k <= 10; k++) begin
      tick;
      n = (k - 1) / 3;
      ph = (k - 1) % 3;
      e = {ph == 0 && n < 3, 1'b0, ph == 2 && n < 3, 1'b0,
           ph < 2 && n < 3, 1'b0};
      vecs++;
      if (fl !== e) begin
        errs++;
        $display("FAIL b2b_flags c%0d got %b exp %b", k, fl, e);
      end
      if (ph == 0 && n < 3) begin
        if (n < 2) addr0 = AW'(n + 2);
        else req0 = 0;
      end
      if (ph == 2 && n < 3) begin
        vecs++;
        if (rdata0 !== d[n]) begin
          errs++;
          $display("FAIL b2b_rdata%0d got %h exp %h", n, rdata0, d[n]);
        end
      end
    end
  endtask

  task automatic test_late_req;
    logic [DW-1:0] dx, dy;
    logic [5:0]    e;
    do_reset;
    dx = $urandom | 32'h1;
    dy = $urandom | 32'h1;
    preload(12'h050, dx);
    preload(12'h060, dy);
    req0 = 1; wren0 = 0; addr0 = 12'h050;
    for (int k = 1; k <= 6; k++) begin
      tick;
      e = {k == 1, k == 4, k == 3, k == 6, (k inside {1, 2, 4, 5}), 1'b0};
      vecs++;
      if (fl !== e) begin
        errs++;
        $display("FAIL late_flags c%0d got %b exp %b", k, fl, e);
      end
      if (k == 1) req0 = 0;
      if (k == 2) begin
        req1 = 1; wren1 = 0; addr1 = 12'h060;
      end
      if (k == 4) req1 = 0;
      if (k == 3) begin
        vecs++;
        if (rdata0 !== dx) begin
          errs++;
          $display("FAIL late_rdata0 got %h exp %h", rdata0, dx);
        end
      end
      if (k == 6) begin
        vecs++;
        if (rdata1 !== dy) begin
          errs++;
          $display("FAIL late_rdata1 got %h exp %h", rdata1, dy);
        end
      end
    end
  endtask

  task automatic test_reset_mid_write;
    logic [DW-1:0] v;
    logic [5:0]    e;
    v = $urandom;
    if (v == 32'hAAAA5555) v = 32'h5555AAAA;
    preload(12'h020, v);
    req0 = 1; wren0 = 1; addr0 = 12'h020; wdata0 = 32'hAAAA5555;
    tick;
    vecs++;
    if (fl !== 6'b100011) begin
      errs++;
      $display("FAIL rmw_issue got %b exp %b", fl, 6'b100011);
    end
    req0 = 0; wren0 = 0;
    reset = 1;
    tick;
    reset = 0;
    vecs++;
    if (fl !== 6'b0) begin
      errs++;
      $display("FAIL rmw_flags got %b exp %b", fl, 6'b0);
    end
    vecs++;
    if ({address_dmem, data, rdata0, rdata1} !== '0) begin
      errs++;
      $display("FAIL rmw_regs got %h %h %h %h exp 0",
               address_dmem, data, rdata0, rdata1);
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      vecs++;
      if (fl !== 6'b0) begin
        errs++;
        $display("FAIL rmw_quiet c%0d got %b exp %b", k, fl, 6'b0);
      end
    end
    vecs++;
    if (mem[12'h020] !== v) begin
      errs++;
      $display("FAIL rmw_mem got %h exp %h", mem[12'h020], v);
    end
    req0 = 1; req1 = 1; addr0 = 12'h020; addr1 = 12'h021;
    for (int k = 1; k <= 7; k++) begin
      tick;
      e = {k == 1, k == 4, k == 3, k == 6, (k inside {1, 2, 4, 5}), 1'b0};
      vecs++;
      if (fl !== e) begin
        errs++;
        $display("FAIL rmw_tie c%0d got %b exp %b", k, fl, e);
      end
      if (k == 1) req0 = 0;
      if (k == 4) req1 = 0;
    end
  endtask

  task automatic test_random;
    int            m_free, m_gnt, m_last;
    logic          m_own, m_wr, w1;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rval;
    logic [DW-1:0] exp_rd [2];
    logic [5:0]    e;
    logic          ebusy;
    do_reset;
    for (int a = 0; a < 16; a++) preload(AW'(a), $urandom);
    m_free = 0; m_gnt = -10; m_last = 1;
    m_own = 0; m_wr = 0; m_addr = '0; m_wdata = '0; m_rval = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) tick;
      if (c == m_gnt + 2 && !m_wr) exp_rd[m_own] = m_rval;
      ebusy = (c == m_gnt || c == m_gnt + 1);
      e = {c == m_gnt && !m_own, c == m_gnt && m_own,
           c == m_gnt + 2 && !m_own, c == m_gnt + 2 && m_own,
           ebusy, c == m_gnt && m_wr};
      vecs++;
      if (fl !== e) begin
        errs++;
        $display("FAIL rnd_flags c%0d got %b exp %b", c, fl, e);
      end
      if (ebusy) begin
        vecs++;
        if (address_dmem !== m_addr ||
            (c == m_gnt && m_wr && data !== m_wdata)) begin
          errs++;
          $display("FAIL rnd_bus c%0d got %h %h exp %h %h",
                   c, address_dmem, data, m_addr, m_wdata);
        end
      end
      vecs++;
      if (rdata0 !== exp_rd[0] || rdata1 !== exp_rd[1]) begin
        errs++;
        $display("FAIL rnd_rdata c%0d got %h %h exp %h %h",
                 c, rdata0, rdata1, exp_rd[0], exp_rd[1]);
      end
      if (req0 ? gnt0 : ($urandom_range(0, 2) == 0)) begin
        req0 = req0 ? ($urandom_range(0, 3) == 0) : 1'b1;
        wren0 = 1'($urandom_range(0, 1));
        addr0 = AW'($urandom_range(0, 15));
        wdata0 = $urandom;
      end
      if (req1 ? gnt1 : ($urandom_range(0, 2) == 0)) begin
        req1 = req1 ? ($urandom_range(0, 3) == 0) : 1'b1;
        wren1 = 1'($urandom_range(0, 1));
        addr1 = AW'($urandom_range(0, 15));
        wdata1 = $urandom;
      end
      if (c >= m_free && (req0 || req1)) begin
        w1 = (req0 && req1) ? (m_last == 0) : req1;
        m_last = int'(w1);
        m_own = w1;
        m_wr = w1 ? wren1 : wren0;
        m_addr = w1 ? addr1 : addr0;
        m_wdata = w1 ? wdata1 : wdata0;
        if (m_wr) ref_mem[m_addr] = m_wdata;
        else m_rval = ref_mem[m_addr];
        m_gnt = c + 1;
        m_free = c + 3;
      end
    end
    idle_inputs;
    repeat (4) tick;
  endtask

  initial begin
    reset = 1;
    idle_inputs;
    test_reset;
    test_single_read;
    test_write_read_p1;
    test_tie;
    test_back_to_back;
    test_late_req;
    test_reset_mid_write;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1);
  end

endmodule
